// File: rtl/npc_pkg.sv
// Shared NPC core definitions: IFU state encoding and core-wide constants.
package npc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

    localparam logic [31:0] NPC_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NPC_INST_NOP  = 32'h0000_0013;

endpackage

// File: rtl/npc_ifu.sv
// NPC instruction fetch unit: owns the PC, keeps one imem request in flight,
// hands fetched words to decode and absorbs redirects from execute.
module npc_ifu
    import npc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = NPC_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    ifu_state_t        state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] pend_pc_r, pend_pc_s;
    logic              kill_r, kill_s;
    logic              latch_s;
    logic [INST_W-1:0] inst_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic              inst_fault_r;
    logic [ADDR_W-1:0] redir_pc_s;

    assign redir_pc_s = {redirect_pc[ADDR_W-1:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        pend_pc_s = pend_pc_r;
        kill_s    = kill_r;
        latch_s   = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = REQ;
                pc_s    = RESET_PC;
            end
            REQ: begin
                // The accepted request is never withdrawn; a redirect only marks it stale.
                if (redirect_valid) begin
                    pend_pc_s = redir_pc_s;
                    kill_s    = 1'b1;
                end else begin
                    kill_s    = kill_r;
                end
                if (imem_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_s = REQ;
                        pc_s    = redir_pc_s;
                        kill_s  = 1'b0;
                    end else if (kill_r) begin
                        state_s = REQ;
                        pc_s    = pend_pc_r;
                        kill_s  = 1'b0;
                    end else begin
                        state_s = HOLD;
                        latch_s = 1'b1;
                        pc_s    = pc_r + ADDR_W'(3'd4);
                    end
                end else if (redirect_valid) begin
                    pend_pc_s = redir_pc_s;
                    kill_s    = 1'b1;
                end else begin
                    state_s   = WAIT;
                end
            end
            HOLD: begin
                // A redirect wins over sequential PC even if decode accepts this cycle.
                if (redirect_valid) begin
                    state_s = REQ;
                    pc_s    = redir_pc_s;
                end else if (inst_ready) begin
                    state_s = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // PC, redirect bookkeeping and decode-facing output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            pend_pc_r    <= RESET_PC;
            kill_r       <= 1'b0;
            inst_r       <= {INST_W{1'b0}};
            inst_pc_r    <= RESET_PC;
            inst_fault_r <= 1'b0;
        end else begin
            pc_r      <= pc_s;
            pend_pc_r <= pend_pc_s;
            kill_r    <= kill_s;
            if (latch_s) begin
                inst_r       <= imem_rsp_err ? {INST_W{1'b0}} : imem_rsp_data;
                inst_pc_r    <= pc_r;
                inst_fault_r <= imem_rsp_err;
            end else begin
                inst_r       <= inst_r;
                inst_pc_r    <= inst_pc_r;
                inst_fault_r <= inst_fault_r;
            end
        end
    end

    assign imem_req_valid = (state_r == REQ);
    assign imem_req_addr  = pc_r;
    assign inst_valid     = (state_r == HOLD);
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign inst_fault     = inst_fault_r;

endmodule

// File: tb/tb_npc_ifu.sv
// Bench for npc_ifu: directed vector table, async-reset sequence, and a
// randomized run checked against a transaction-level fetch-stream model.
module tb_npc_ifu;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready, inst_fault;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    npc_ifu #(.ADDR_W(32), .INST_W(32), .RESET_PC(NPC_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rq_rdy; logic rs_v; logic [31:0] rs_d; logic rs_e;
        logic        i_rdy;  logic rd_v; logic [31:0] rd_pc;
        logic        e_rqv;  logic [31:0] e_addr;
        logic        e_iv;   logic [31:0] e_pc; logic [31:0] e_inst; logic e_flt;
    } vec_t;

    function automatic vec_t mk(input logic rq_rdy, input logic rs_v, input logic [31:0] rs_d,
                                input logic rs_e, input logic i_rdy, input logic rd_v,
                                input logic [31:0] rd_pc, input logic e_rqv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_flt);
        vec_t v;
        v.rq_rdy = rq_rdy; v.rs_v = rs_v; v.rs_d = rs_d; v.rs_e = rs_e;
        v.i_rdy = i_rdy; v.rd_v = rd_v; v.rd_pc = rd_pc;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_flt = e_flt;
        return v;
    endfunction

    // Memory contents and fault map used by the randomized run
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_0013) + {a[15:0], a[31:16]};
    endfunction
    function automatic logic mem_err(input logic [31:0] a);
        return (a[4:2] == 3'b101);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"},  imem_req_addr, NPC_RESET_PC);
        check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_inst"},      inst, 32'd0);
        check({tag, "_inst_pc"},   inst_pc, NPC_RESET_PC);
        check({tag, "_inst_fault"}, {31'd0, inst_fault}, 32'd0);
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        imem_rsp_err = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    endtask

    vec_t tbl[27];

    initial begin
        logic [31:0] exp_pc, held_pc, held_inst, exp_inst, pend_addr;
        logic        held_flt, prev_iv, pend;
        int          due, idle;

        //            rq rs  rs_d           er ir rd  rd_pc          rqv addr           iv pc             inst          flt
        tbl[0]  = mk(0, 0, 32'd0,          0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[1]  = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0000, 0, 32'd0,         32'd0,         0);
        tbl[2]  = mk(0, 1, NPC_INST_NOP,   0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[3]  = mk(0, 0, 32'd0,          0, 1, 0, 32'd0,         0, 32'd0,         1, 32'h8000_0000, NPC_INST_NOP,  0);
        tbl[4]  = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0004, 0, 32'd0,         32'd0,         0);
        tbl[5]  = mk(0, 1, 32'h0010_0093,  0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, 0, 32'd0,       0, 0, 0, 32'd0,         0, 32'd0,         1, 32'h8000_0004, 32'h0010_0093, 0);
        tbl[11] = mk(0, 0, 32'd0,          0, 1, 0, 32'd0,         0, 32'd0,         1, 32'h8000_0004, 32'h0010_0093, 0);
        tbl[12] = mk(0, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0008, 0, 32'd0,         32'd0,         0);
        tbl[13] = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0008, 0, 32'd0,         32'd0,         0);
        tbl[14] = mk(0, 0, 32'd0,          0, 0, 1, 32'h8000_0102, 0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[15] = mk(0, 1, 32'hDEAD_BEEF,  0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[16] = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0100, 0, 32'd0,         32'd0,         0);
        tbl[17] = mk(0, 1, 32'h0000_0011,  0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[18] = mk(0, 0, 32'd0,          0, 1, 1, 32'h8000_0010, 0, 32'd0,         1, 32'h8000_0100, 32'h0000_0011, 0);
        tbl[19] = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h8000_0010, 0, 32'd0,         32'd0,         0);
        tbl[20] = mk(0, 1, 32'hFFFF_FFFF,  1, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[21] = mk(0, 0, 32'd0,          0, 0, 1, 32'hFFFF_FFFF, 0, 32'd0,         1, 32'h8000_0010, 32'd0,         1);
        tbl[22] = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'hFFFF_FFFC, 0, 32'd0,         32'd0,         0);
        tbl[23] = mk(0, 1, 32'h0000_0022,  0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);
        tbl[24] = mk(0, 0, 32'd0,          0, 1, 0, 32'd0,         0, 32'd0,         1, 32'hFFFF_FFFC, 32'h0000_0022, 0);
        tbl[25] = mk(1, 0, 32'd0,          0, 0, 0, 32'd0,         1, 32'h0000_0000, 0, 32'd0,         32'd0,         0);
        tbl[26] = mk(0, 0, 32'd0,          0, 0, 0, 32'd0,         0, 32'd0,         0, 32'd0,         32'd0,         0);

        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed table: inputs for cycle i, outputs observed in cycle i
        for (int i = 0; i < 27; i++) begin
            imem_req_ready = tbl[i].rq_rdy; imem_rsp_valid = tbl[i].rs_v;
            imem_rsp_data = tbl[i].rs_d;    imem_rsp_err = tbl[i].rs_e;
            inst_ready = tbl[i].i_rdy;      redirect_valid = tbl[i].rd_v;
            redirect_pc = tbl[i].rd_pc;
            check($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rqv});
            check($sformatf("vec%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
            if (tbl[i].e_rqv)
                check($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            if (tbl[i].e_iv) begin
                check($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
                check($sformatf("vec%0d_inst", i), inst, tbl[i].e_inst);
                check($sformatf("vec%0d_inst_fault", i), {31'd0, inst_fault}, {31'd0, tbl[i].e_flt});
            end
            @(negedge clk);
        end

        // Async reset while waiting for a response; late response must be ignored
        drive_idle();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        check({31'd0, inst_valid} == 32'd0 ? "late_rsp_boot_iv" : "late_rsp_boot_iv", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("late_rsp_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("late_rsp_req_addr", imem_req_addr, NPC_RESET_PC);
        @(negedge clk);
        check("late_rsp_still_req", {31'd0, imem_req_valid}, 32'd1);
        check("late_rsp_iv", {31'd0, inst_valid}, 32'd0);
        drive_idle();

        // Randomized run against a fetch-stream model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = NPC_RESET_PC; prev_iv = 1'b0; pend = 1'b0; due = 0; idle = 0;
        pend_addr = 32'd0; held_pc = 32'd0; held_inst = 32'd0; held_flt = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (inst_valid && !prev_iv) begin
                exp_inst = mem_err(exp_pc) ? 32'd0 : mem_word(exp_pc);
                check("rnd_inst_pc", inst_pc, exp_pc);
                check("rnd_inst", inst, exp_inst);
                check("rnd_inst_fault", {31'd0, inst_fault}, {31'd0, mem_err(exp_pc)});
                held_pc = inst_pc; held_inst = inst; held_flt = inst_fault;
                idle = 0;
            end else if (inst_valid) begin
                check("rnd_hold_pc", inst_pc, held_pc);
                check("rnd_hold_inst", inst, held_inst);
            end
            check("rnd_one_outstanding", {31'd0, imem_req_valid & (inst_valid | pend)}, 32'd0);
            idle++;
            if (idle > 100) begin
                check("rnd_progress_cycles", idle, 32'd100);
                break;
            end

            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = (t >= 2) && ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : (32'h8000_0000 | 32'($urandom_range(0, 511)));
            if (pend && t == due) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                imem_rsp_err   = mem_err(pend_addr);
                pend = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                imem_rsp_err   = 1'($urandom_range(0, 1));
            end

            if (redirect_valid)
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (inst_valid && inst_ready)
                exp_pc = exp_pc + 32'd4;
            if (imem_req_valid && imem_req_ready) begin
                check("rnd_req_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
                pend = 1'b1;
                pend_addr = imem_req_addr;
                due = t + $urandom_range(1, 3);
            end
            prev_iv = inst_valid;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
